// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Round-robin arbiter sharing the frame-buffer write port among
//               N_REQ pixel engines. Valid/ready handshake per engine,
//               registered write stage, out-of-range rejection with a sticky
//               error, and a frame-complete pulse every DEPTH in-range writes.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 4800
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_hold,
   input  logic [N_REQ-1:0]              i_req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
   output logic [N_REQ-1:0]              o_req_ready,
   output logic                          o_we,
   output logic [ADDR_WIDTH-1:0]         o_addr_wr,
   output logic [DATA_WIDTH-1:0]         o_data_wr,
   output logic [$clog2(N_REQ)-1:0]      o_grant_id,
   output logic                          o_frame_done,
   output logic                          o_err
);

   localparam int                  c_idw   = $clog2(N_REQ);
   localparam int                  c_cw    = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [c_cw-1:0]     c_last  = c_cw'(DEPTH - 1);
   localparam logic [c_idw-1:0]    c_ptr0  = c_idw'(N_REQ - 1);

   logic [c_idw-1:0]      r_ptr;
   logic [c_idw-1:0]      w_sel;
   logic                  w_found;
   logic                  w_take;
   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [c_cw-1:0]       r_cnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [c_idw-1:0]      r_id;
   logic                  r_done;
   logic                  r_err;

   // Round-robin search: first valid engine starting just above the pointer.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req_valid[k] && (((int'(r_ptr) + off) % N_REQ) == k)) begin
               w_found = 1'b1;
               w_sel   = c_idw'(k);
            end
         end
      end
   end

   // A transfer needs a winner, no hold, and no reset in progress.
   assign w_take = w_found & ~i_hold & ~rst;

   // One-hot ready for the winner and a mux of its address/data.
   always_comb begin
      o_req_ready = '0;
      w_addr      = '0;
      w_data      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_sel == c_idw'(k)) begin
            w_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (w_take) begin
         o_req_ready[w_sel] = 1'b1;
      end
   end

   assign w_in_range = ({1'b0, w_addr} < c_depth);

   // Write stage, pointer update, frame counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_id   <= '0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
         r_ptr  <= c_ptr0;
      end else begin
         r_we   <= w_take & w_in_range;
         r_done <= w_take & w_in_range & (r_cnt == c_last);
         if (w_take) begin
            r_addr <= w_addr;
            r_data <= w_data;
            r_id   <= w_sel;
            r_ptr  <= w_sel;
            if (w_in_range) begin
               r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign o_we         = r_we;
   assign o_addr_wr    = r_addr;
   assign o_data_wr    = r_data;
   assign o_grant_id   = r_id;
   assign o_frame_done = r_done;
   assign o_err        = r_err;

endmodule
`default_nettype wire
